// File: rtl/fp_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_seq
// Brief    : Multi-cycle IEEE-754 multiplier, shift-add datapath, RNE, FTZ.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_seq #(
    parameter int EXPONENT_BITS = 8,
    parameter int FRACTION_BITS = 23
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [EXPONENT_BITS+FRACTION_BITS:0]   a,
    input  logic [EXPONENT_BITS+FRACTION_BITS:0]   b,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [EXPONENT_BITS+FRACTION_BITS:0]   result,
    output logic [3:0]                             flags
);

    localparam int W  = 1 + EXPONENT_BITS + FRACTION_BITS;
    localparam int S  = FRACTION_BITS + 1;
    localparam int PW = 2 * S;
    localparam int EW = EXPONENT_BITS + 2;
    localparam int CW = $clog2(FRACTION_BITS + 1);

    localparam logic signed [EW-1:0] c_BIAS     = EW'((1 << (EXPONENT_BITS - 1)) - 1);
    localparam logic signed [EW-1:0] c_EXP_MAX  = EW'((1 << EXPONENT_BITS) - 1);
    localparam logic signed [EW-1:0] c_EXP_ZERO = '0;
    localparam logic signed [EW-1:0] c_EXP_ONE  = EW'(1);
    localparam logic [W-1:0]         c_QNAN     = {1'b0, {EXPONENT_BITS{1'b1}}, 1'b1, {(FRACTION_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_MULT  = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [W-1:0]           r_result;
    logic [3:0]             r_flags;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    logic                   r_sign;
    logic signed [EW-1:0]   r_exp;
    logic [S-1:0]           r_ma;
    logic [PW-1:0]          r_prod;
    logic [CW-1:0]          r_cnt;
    logic [S-1:0]           r_sig;
    logic                   r_guard;
    logic                   r_sticky;

    // Operand classification
    logic [EXPONENT_BITS-1:0] w_ea, w_eb;
    logic [FRACTION_BITS-1:0] w_fa, w_fb;
    logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sign;
    logic signed [EW-1:0] w_exp_sum;

    assign w_ea      = r_a[W-2:FRACTION_BITS];
    assign w_eb      = r_b[W-2:FRACTION_BITS];
    assign w_fa      = r_a[FRACTION_BITS-1:0];
    assign w_fb      = r_b[FRACTION_BITS-1:0];
    assign w_a_nan   = (&w_ea) && (|w_fa);
    assign w_b_nan   = (&w_eb) && (|w_fb);
    assign w_a_inf   = (&w_ea) && !(|w_fa);
    assign w_b_inf   = (&w_eb) && !(|w_fb);
    assign w_a_zero  = !(|w_ea);
    assign w_b_zero  = !(|w_eb);
    assign w_sign    = r_a[W-1] ^ r_b[W-1];
    assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_BIAS;

    // One shift-add step: multiplier sits in the low half and is consumed LSB first
    logic [S:0] w_add;
    assign w_add = {1'b0, r_prod[PW-1:S]} + (r_prod[0] ? {1'b0, r_ma} : {(S+1){1'b0}});

    // Rounding
    logic                 w_round_up;
    logic [S:0]           w_sum;
    logic [FRACTION_BITS-1:0] w_frac_rnd;
    logic signed [EW-1:0] w_exp_rnd;

    assign w_round_up = r_guard && (r_sticky || r_sig[0]);
    assign w_sum      = {1'b0, r_sig} + {{S{1'b0}}, w_round_up};
    assign w_frac_rnd = w_sum[S] ? w_sum[FRACTION_BITS:1] : w_sum[FRACTION_BITS-1:0];
    assign w_exp_rnd  = r_exp + $signed({{(EW-1){1'b0}}, w_sum[S]});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_ma        <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_sig       <= '0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_sign <= w_sign;
                    if (w_a_nan || w_b_nan) begin
                        r_result    <= c_QNAN;
                        r_flags     <= 4'b0000;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
                        r_result    <= c_QNAN;
                        r_flags     <= 4'b1000;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_a_inf || w_b_inf) begin
                        r_result    <= {w_sign, {EXPONENT_BITS{1'b1}}, {FRACTION_BITS{1'b0}}};
                        r_flags     <= 4'b0000;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_a_zero || w_b_zero) begin
                        r_result    <= {w_sign, {(W-1){1'b0}}};
                        r_flags     <= 4'b0000;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_exp   <= w_exp_sum;
                        r_ma    <= {1'b1, w_fa};
                        r_prod  <= {{S{1'b0}}, 1'b1, w_fb};
                        r_cnt   <= CW'(FRACTION_BITS);
                        r_state <= S_MULT;
                    end
                end
                S_MULT: begin
                    r_prod <= {w_add, r_prod[S-1:1]};
                    if (r_cnt == '0) begin
                        r_state <= S_NORM;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_NORM: begin
                    if (r_prod[PW-1]) begin
                        r_sig    <= r_prod[PW-1:S];
                        r_guard  <= r_prod[S-1];
                        r_sticky <= |r_prod[S-2:0];
                        r_exp    <= r_exp + c_EXP_ONE;
                    end else begin
                        r_sig    <= r_prod[PW-2:S-1];
                        r_guard  <= r_prod[S-2];
                        r_sticky <= |r_prod[S-3:0];
                    end
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (w_exp_rnd >= c_EXP_MAX) begin
                        r_result <= {r_sign, {EXPONENT_BITS{1'b1}}, {FRACTION_BITS{1'b0}}};
                        r_flags  <= 4'b0101;
                    end else if (w_exp_rnd <= c_EXP_ZERO) begin
                        r_result <= {r_sign, {(W-1){1'b0}}};
                        r_flags  <= 4'b0011;
                    end else begin
                        r_result <= {r_sign, w_exp_rnd[EXPONENT_BITS-1:0], w_frac_rnd};
                        r_flags  <= {3'b000, r_guard || r_sticky};
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_seq
// Brief    : Directed vectors against an exact-integer float multiply model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_vec = 0;
    int n_err = 0;

    logic [35:0] q_exp [$];
    logic [35:0] m_tmp;

    fp_mul_seq #(.EXPONENT_BITS(8), .FRACTION_BITS(23)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Exact product of the significands, then RNE to 24 bits by remainder comparison
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic s;
        int ex, ey, p, sh, e;
        bit nx, ny, ix, iy, zx, zy, inexact;
        longint unsigned m, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny) return {32'h7FC00000, 4'b0000};
        if ((ix && zy) || (zx && iy)) return {32'h7FC00000, 4'b1000};
        if (ix || iy) return {s, 8'hFF, 23'h0, 4'b0000};
        if (zx || zy) return {s, 31'h0, 4'b0000};
        m = {40'h0, 1'b1, x[22:0]};
        m = m * {40'h0, 1'b1, y[22:0]};
        p = 0;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        sh   = p - 23;
        q    = m >> sh;
        rem  = m - (q << sh);
        half = 64'd1 << (sh - 1);
        inexact = (rem != 0);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        e = ex + ey - 127 + (p - 46);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0, 4'b0101};
        if (e <= 0)   return {s, 31'h0, 4'b0011};
        return {s, e[7:0], q[22:0], 3'b000, inexact};
    endfunction

    // Scoreboard: enqueue the model's answer on each accept, drop it on each handoff
    always @(posedge clock) begin
        if (reset) begin
            q_exp.delete();
        end else begin
            if (out_valid && out_ready && q_exp.size() > 0) void'(q_exp.pop_front());
            if (in_valid && in_ready) begin
                m_tmp = model(a, b);
                q_exp.push_back(m_tmp);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_out_valid", {35'h0, out_valid}, 36'h0);
            end else begin
                chk("model_result", {4'h0, result}, {4'h0, q_exp[0][35:4]});
                chk("model_flags", {32'h0, flags}, {32'h0, q_exp[0][3:0]});
                chk("in_ready_while_busy", {35'h0, in_ready}, 36'h0);
            end
        end
    end

    // Latency counts the accept edge as edge 1
    task automatic run(input logic [31:0] x, input logic [31:0] y, input int lat,
                       input bit lit, input logic [31:0] er, input logic [3:0] ef);
        int n;
        @(negedge clock);
        chk("in_ready_idle", {35'h0, in_ready}, 36'h1);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 1;
        while (n < 100) begin
            @(posedge clock);
            n++;
            #1;
            if (out_valid) break;
        end
        chk("latency", 36'(n), 36'(lat));
        if (lit) begin
            chk("lit_result", {4'h0, result}, {4'h0, er});
            chk("lit_flags", {32'h0, flags}, {32'h0, ef});
        end
        @(posedge clock);
        #1;
        chk("handoff_out_valid", {35'h0, out_valid}, 36'h0);
        chk("handoff_in_ready", {35'h0, in_ready}, 36'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit saw;
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_in_ready", {35'h0, in_ready}, 36'h1);
        chk("reset_out_valid", {35'h0, out_valid}, 36'h0);
        chk("reset_result", {4'h0, result}, 36'h0);
        chk("reset_flags", {32'h0, flags}, 36'h0);
        reset = 1'b0;

        // Pin the model itself
        chk("model_pin_1p5x2", model(32'h3FC00000, 32'h40000000), {32'h40400000, 4'b0000});
        chk("model_pin_lsb", model(32'h3F800001, 32'h3F800001), {32'h3F800002, 4'b0001});
        chk("model_pin_ovf", model(32'h7F7FFFFF, 32'h40000000), {32'h7F800000, 4'b0101});
        chk("model_pin_udf", model(32'h00800000, 32'h3F000000), {32'h00000000, 4'b0011});

        run(32'h3FC00000, 32'h40000000, 28, 1, 32'h40400000, 4'b0000);
        run(32'h3F800001, 32'h3F800001, 28, 1, 32'h3F800002, 4'b0001);
        run(32'h7F800000, 32'h00000000, 2,  1, 32'h7FC00000, 4'b1000);
        run(32'hFF800000, 32'h40000000, 2,  1, 32'hFF800000, 4'b0000);
        run(32'h00000001, 32'h40000000, 2,  1, 32'h00000000, 4'b0000);
        run(32'h7F7FFFFF, 32'h40000000, 28, 1, 32'h7F800000, 4'b0101);
        run(32'h00800000, 32'h3F000000, 28, 1, 32'h00000000, 4'b0011);
        run(32'h7F800001, 32'h00000000, 2,  1, 32'h7FC00000, 4'b0000);
        run(32'hBF800000, 32'h00000000, 2,  1, 32'h80000000, 4'b0000);
        run(32'h7F800000, 32'hFF800000, 2,  1, 32'hFF800000, 4'b0000);
        run(32'h40490FDB, 32'h40490FDB, 28, 0, 32'h0, 4'h0);
        run(32'hC0000000, 32'h3EAAAAAB, 28, 0, 32'h0, 4'h0);
        run(32'h3FFFFFFF, 32'h3FFFFFFF, 28, 0, 32'h0, 4'h0);
        run(32'h3F800001, 32'h3F7FFFFF, 28, 0, 32'h0, 4'h0);

        // Backpressure: result held, in_valid ignored while the consumer stalls
        @(negedge clock);
        a = 32'h3FC00000;
        b = 32'h40000000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clock);
            n++;
            #1;
        end
        chk("bp_latency", 36'(n), 36'd28);
        repeat (10) begin
            @(negedge clock);
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            chk("bp_out_valid", {35'h0, out_valid}, 36'h1);
            chk("bp_result", {4'h0, result}, {4'h0, 32'h40400000});
            chk("bp_flags", {32'h0, flags}, 36'h0);
            chk("bp_in_ready", {35'h0, in_ready}, 36'h0);
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_handoff_out_valid", {35'h0, out_valid}, 36'h0);
        chk("bp_handoff_in_ready", {35'h0, in_ready}, 36'h1);

        // Reset in the middle of MULT aborts the operation
        @(negedge clock);
        a = 32'h3FC00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) saw = 1'b1;
        end
        chk("reset_abort_no_valid", {35'h0, saw}, 36'h0);
        run(32'h3FC00000, 32'h40000000, 28, 1, 32'h40400000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
